fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 162 ++++++++++++++++
 tb/tb_fetch_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one instruction-memory request at a time,
// buffers returned words with their addresses in a small circular FIFO, and
// presents the head entry to the decode stage with zero latency.
//
// Handshake semantics: imem_req is a single-cycle request accepted on the
// rising edge where it is high; imem_valid is a single-cycle response that
// answers the one outstanding request. A queue entry is consumed on a rising
// edge where instr_valid=1, stall=0 and redirect=0. There is no ready signal
// towards memory; the FIFO slot reserved at request time guarantees that every
// response has room.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic [1:0]  dbg_state
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // no request outstanding
        S_WAIT = 2'd1,  // one live request outstanding
        S_DROP = 2'd2   // request outstanding whose data must be thrown away
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     fetch_pc_q, fetch_pc_d;
    logic [15:0]     req_pc_q, req_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     mem_pc_q    [DEPTH];
    logic [15:0]     mem_instr_q [DEPTH];

    logic            pop;
    logic            push;
    logic            full;
    logic            req_int;

    // Queue occupancy and the push/pop qualifiers shared by FSM and pointers.
    always_comb begin
        full = (count_q == CW'(DEPTH));
        pop  = (count_q != '0) && !stall && !redirect;
        push = (state_q == S_WAIT) && imem_valid && !redirect;
    end

    // Fetch FSM next state, request generation and fetch address update.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req_int    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // imem_valid here belongs to nothing and is ignored.
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (!full || pop) begin
                    req_int    = 1'b1;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 16'd2;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = imem_valid ? S_IDLE : S_DROP;
                end else if (imem_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                // The stale response retires the outstanding request.
                if (imem_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request outputs; reset forces the request low immediately.
    always_comb begin
        imem_req  = req_int && reset_n;
        imem_addr = fetch_pc_q;
        dbg_state = state_q;
    end

    // Head/tail/count update; redirect flushes the whole queue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
            end
            if (pop) begin
                head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Entry storage; contents are only observable while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[tail_q]    <= req_pc_q;
            mem_instr_q[tail_q] <= imem_rdata;
        end
    end

    // Head entry presented combinationally; zeros while the queue is empty.
    always_comb begin
        instr_valid = (count_q != '0);
        instr_out   = instr_valid ? mem_instr_q[head_q] : 16'h0000;
        pc_out      = instr_valid ? mem_pc_q[head_q]    : 16'h0000;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: one linear initial block of steps, a
// background instruction-memory model with programmable latency, and
// immediate assertions at every comparison.
module tb_fetch_queue;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    // Memory model state
    bit          mem_auto = 1'b0;
    int          mem_lat  = 1;
    bit          pend     = 1'b0;
    int          cnt      = 0;
    logic [15:0] paddr    = 16'h0000;
    logic        req_d1   = 1'b0;
    logic [15:0] addr_d1  = 16'h0000;

    fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .dbg_state   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'hBEEF;
    endfunction

    // Capture accepted requests like a register on the memory side.
    always @(posedge clk) begin
        req_d1  <= imem_req;
        addr_d1 <= imem_addr;
    end

    // Memory responder: answers each accepted request mem_lat cycles later.
    always @(negedge clk) begin
        if (mem_auto) begin
            imem_valid = 1'b0;
            if (req_d1) begin
                pend  = 1'b1;
                cnt   = mem_lat;
                paddr = addr_d1;
            end
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mdata(paddr);
                    pend       = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, apply inputs, let outputs settle.
    task automatic step(input logic st, input logic rd, input logic [15:0] rpc,
                        input logic v, input logic [15:0] data);
        @(negedge clk);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        if (!mem_auto) begin
            imem_valid = v;
            imem_rdata = data;
        end
        #1;
    endtask

    // Reset for two cycles, then release; returns in the first cycle after release.
    task automatic do_reset(input bit auto, input int lat, input logic st);
        @(negedge clk);
        reset_n     = 1'b0;
        stall       = st;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        mem_auto    = auto;
        mem_lat     = lat;
        #1;
        pend        = 1'b0;
        imem_valid  = 1'b0;
        imem_rdata  = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    logic [15:0] fill_addr [4];
    logic [15:0] drain_pc  [5];
    int          reqs;

    initial begin
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_valid  = 1'b0;
        imem_rdata  = 16'h0000;
        mem_auto    = 1'b1;
        mem_lat     = 1;

        // ---- Reset state and straight-line fetch, 1-cycle memory ----
        @(negedge clk);
        #1;
        chk("rst_req",   imem_req,    1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr_out,   16'h0000);
        chk("rst_pc",    pc_out,      16'h0000);
        chk("rst_state", dbg_state,   ST_IDLE);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("first_req",  imem_req,  1'b1);
        chk("first_addr", imem_addr, 16'h0000);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("c1_req",   imem_req,    1'b0);
        chk("c1_valid", instr_valid, 1'b0);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("c2_req",   imem_req,    1'b1);
        chk("c2_addr",  imem_addr,   16'h0002);
        chk("c2_valid", instr_valid, 1'b1);
        chk("c2_pc",    pc_out,      16'h0000);
        chk("c2_instr", instr_out,   16'hBEEF);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("c3_req", imem_req, 1'b0);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("c4_addr",  imem_addr, 16'h0004);
        chk("c4_pc",    pc_out,    16'h0002);
        chk("c4_instr", instr_out, 16'hBEED);
        step(0, 0, 16'h0, 0, 16'h0);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("c6_pc",    pc_out,    16'h0004);
        chk("c6_instr", instr_out, 16'hBEEB);

        // ---- Stall held 20 cycles: queue fills to DEPTH, then drains in order ----
        do_reset(1'b1, 1, 1'b1);
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step(1, 0, 16'h0, 0, 16'h0);
            if (imem_req) reqs++;
        end
        chk("stall_reqs",  reqs,        4);
        chk("stall_noreq", imem_req,    1'b0);
        chk("stall_valid", instr_valid, 1'b1);
        chk("stall_head",  pc_out,      16'h0000);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 16'h0, 0, 16'h0);
            chk("drain_valid", instr_valid, 1'b1);
            chk("drain_pc",    pc_out,      16'(2 * k));
            chk("drain_instr", instr_out,   mdata(16'(2 * k)));
            if (k == 0) begin
                chk("full_pop_req",  imem_req,  1'b1);
                chk("full_pop_addr", imem_addr, 16'h0008);
            end
        end

        // ---- Redirect while waiting on a 3-cycle memory ----
        do_reset(1'b1, 3, 1'b0);
        chk("r3_req0", imem_req, 1'b1);
        step(0, 1, 16'h0040, 0, 16'h0);
        chk("r3_req_redir", imem_req,  1'b0);
        chk("r3_st_wait",   dbg_state, ST_WAIT);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("r3_st_drop",   dbg_state,   ST_DROP);
        chk("r3_valid_a",   instr_valid, 1'b0);
        chk("r3_req_drop",  imem_req,    1'b0);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("r3_st_drop2",  dbg_state,   ST_DROP);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("r3_st_idle",   dbg_state,   ST_IDLE);
        chk("r3_valid_b",   instr_valid, 1'b0);
        chk("r3_req_new",   imem_req,    1'b1);
        chk("r3_addr_new",  imem_addr,   16'h0040);

        // ---- Redirect coincident with a response and a would-be pop ----
        do_reset(1'b0, 1, 1'b0);
        step(0, 0, 16'h0, 1, 16'h1111);
        step(1, 0, 16'h0, 0, 16'h0);
        chk("co_req",   imem_req,  1'b1);
        chk("co_addr",  imem_addr, 16'h0002);
        step(0, 1, 16'h1230, 1, 16'h2222);
        chk("co_req_redir", imem_req,  1'b0);
        chk("co_head_pc",   pc_out,    16'h0000);
        chk("co_head_instr", instr_out, 16'h1111);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("co_valid", instr_valid, 1'b0);
        chk("co_instr", instr_out,   16'h0000);
        chk("co_pc",    pc_out,      16'h0000);
        chk("co_state", dbg_state,   ST_IDLE);
        chk("co_req2",  imem_req,    1'b1);
        chk("co_addr2", imem_addr,   16'h1230);
        step(0, 0, 16'h0, 1, 16'h5555);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("co_new_pc",    pc_out,    16'h1230);
        chk("co_new_instr", instr_out, 16'h5555);

        // ---- Address wrap past FFFE and pointer wrap with live entries ----
        fill_addr = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
        drain_pc  = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002, 16'h0004};
        do_reset(1'b1, 1, 1'b1);
        step(1, 0, 16'h0, 0, 16'h0);
        step(1, 1, 16'hFFFC, 0, 16'h0);
        chk("wr_req_redir", imem_req,  1'b0);
        chk("wr_st_idle",   dbg_state, ST_IDLE);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 16'h0, 0, 16'h0);
            if (i % 2 == 0) begin
                chk("wr_fill_req",  imem_req,  1'b1);
                chk("wr_fill_addr", imem_addr, fill_addr[i / 2]);
            end
        end
        step(1, 0, 16'h0, 0, 16'h0);
        chk("wr_full_noreq", imem_req, 1'b0);
        chk("wr_full_head",  pc_out,   16'hFFFC);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 16'h0, 0, 16'h0);
            chk("wr_drain_valid", instr_valid, 1'b1);
            chk("wr_drain_pc",    pc_out,      drain_pc[k]);
            chk("wr_drain_instr", instr_out,   mdata(drain_pc[k]));
            if (k == 0) chk("wr_req_a", imem_addr, 16'h0004);
            if (k == 2) chk("wr_req_b", imem_addr, 16'h0006);
        end

        // ---- Reset pulse during WAIT, late response after release ----
        do_reset(1'b0, 1, 1'b0);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("rp_st_wait", dbg_state, ST_WAIT);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rp_req",   imem_req,    1'b0);
        chk("rp_valid", instr_valid, 1'b0);
        chk("rp_state", dbg_state,   ST_IDLE);
        @(negedge clk);
        reset_n    = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'hDEAD;
        #1;
        chk("rp_late_state", dbg_state, ST_IDLE);
        chk("rp_req2",       imem_req,  1'b1);
        chk("rp_addr2",      imem_addr, 16'h0000);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("rp_late_ignored", instr_valid, 1'b0);
        chk("rp_st_wait2",     dbg_state,   ST_WAIT);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("rp_still_empty", instr_valid, 1'b0);
        step(0, 0, 16'h0, 1, 16'h1234);
        chk("rp_before_push", instr_valid, 1'b0);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("rp_valid2", instr_valid, 1'b1);
        chk("rp_pc2",    pc_out,      16'h0000);
        chk("rp_instr2", instr_out,   16'h1234);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
